// File: rtl/apb_completer.sv
// APB completer: turns each APB transfer into one generic-bus request with wait states until the target is done.
// Optional downstream busy timeout is compiled in when APB_COMPLETER_TIMEOUT_EN is defined.
module apb_completer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] WINDOW_BYTES   = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        ren,
  output logic        wen,
  output logic [3:0]  byte_en,
  input  logic [31:0] rdata,
  input  logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [31:0] WIN_MASK = ~(WINDOW_BYTES - 32'd1);
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic        r_req_write;
  logic [3:0]  r_req_strb;
  logic [31:0] r_resp_data;
  logic        r_err;
  logic        r_abort;

  logic [31:0] w_req_addr_nxt;
  logic [31:0] w_req_wdata_nxt;
  logic        w_req_write_nxt;
  logic [3:0]  w_req_strb_nxt;
  logic [31:0] w_resp_data_nxt;
  logic        w_err_nxt;
  logic        w_abort_nxt;

  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;
  logic        r_ren;
  logic        r_wen;

  logic [31:0] w_prdata_nxt;
  logic        w_pready_nxt;
  logic        w_pslverr_nxt;
  logic        w_ren_nxt;
  logic        w_wen_nxt;

  logic        w_in_window;
  logic        w_aligned;
  logic        w_done;
  logic        w_timeout;
  logic        w_abort;
  logic        w_unused;

  // Window check relies on BASE_ADDR being aligned to the power-of-two window size.
  assign w_in_window = ((PADDR & WIN_MASK) == BASE_ADDR);
  assign w_aligned   = (PADDR[1:0] == 2'b00);
  assign w_done      = (r_state == S_REQ) && !busy;
  assign w_abort     = r_abort || !PSEL;
  assign w_unused    = ^{PENABLE, PPROT, TO_LAST};

`ifdef APB_COMPLETER_TIMEOUT_EN
  logic [7:0] r_to_cnt;

  assign w_timeout = (r_state == S_REQ) && busy && (r_to_cnt == TO_LAST);

  // Busy-cycle counter, zero outside REQ so every request starts counting from 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_to_cnt <= 8'd0;
    end else if (r_state != S_REQ) begin
      r_to_cnt <= 8'd0;
    end else if (busy) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; an aborted request drains and returns silently to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (PSEL) begin
          w_state_nxt = (w_in_window && w_aligned) ? S_REQ : S_ERR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_done || w_timeout) begin
          w_state_nxt = w_abort ? S_IDLE : S_RESP;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request/response register next values.
  always_comb begin
    w_req_addr_nxt  = r_req_addr;
    w_req_wdata_nxt = r_req_wdata;
    w_req_write_nxt = r_req_write;
    w_req_strb_nxt  = r_req_strb;
    w_resp_data_nxt = r_resp_data;
    w_err_nxt       = r_err;
    w_abort_nxt     = r_abort;
    if ((r_state == S_IDLE) && PSEL) begin
      w_req_addr_nxt  = PADDR;
      w_req_wdata_nxt = PWDATA;
      w_req_write_nxt = PWRITE;
      w_req_strb_nxt  = PWRITE ? PSTRB : 4'hF;
      w_abort_nxt     = 1'b0;
    end else if (r_state == S_REQ) begin
      w_abort_nxt = w_abort;
      if (w_done) begin
        w_resp_data_nxt = r_req_write ? 32'h0000_0000 : rdata;
        w_err_nxt       = 1'b0;
      end else if (w_timeout) begin
        w_resp_data_nxt = 32'h0000_0000;
        w_err_nxt       = 1'b1;
      end else begin
        w_resp_data_nxt = r_resp_data;
        w_err_nxt       = r_err;
      end
    end else begin
      w_abort_nxt = r_abort;
    end
  end

  // Request/response registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_req_addr  <= 32'h0000_0000;
      r_req_wdata <= 32'h0000_0000;
      r_req_write <= 1'b0;
      r_req_strb  <= 4'h0;
      r_resp_data <= 32'h0000_0000;
      r_err       <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_req_addr  <= w_req_addr_nxt;
      r_req_wdata <= w_req_wdata_nxt;
      r_req_write <= w_req_write_nxt;
      r_req_strb  <= w_req_strb_nxt;
      r_resp_data <= w_resp_data_nxt;
      r_err       <= w_err_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  // FSM output logic, decoded from the next state so the outputs can be flopped.
  always_comb begin
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = 32'h0000_0000;
    w_ren_nxt     = 1'b0;
    w_wen_nxt     = 1'b0;
    case (w_state_nxt)
      S_REQ: begin
        w_ren_nxt = !w_req_write_nxt;
        w_wen_nxt = w_req_write_nxt;
      end
      S_RESP: begin
        w_pready_nxt  = 1'b1;
        w_pslverr_nxt = w_err_nxt;
        w_prdata_nxt  = w_resp_data_nxt;
      end
      S_ERR: begin
        w_pready_nxt  = 1'b1;
        w_pslverr_nxt = 1'b1;
      end
      default: begin
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
      end
    endcase
  end

  // Registered APB response and downstream request strobes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_prdata  <= 32'h0000_0000;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
    end else begin
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_ren     <= w_ren_nxt;
      r_wen     <= w_wen_nxt;
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;
  assign ren     = r_ren;
  assign wen     = r_wen;
  assign addr    = r_req_addr;
  assign wdata   = r_req_wdata;
  assign byte_en = r_req_strb;

endmodule

// File: doc/apb_completer.md
# apb_completer

APB completer bridge: accepts APB transfers from an APB requester and converts each one into a single generic-bus request toward a downstream memory or peripheral. It sits at the far end of an APB segment and presents `generic_bus_if`-style request signals to the target. The bridge inserts wait states until the target finishes, then returns read data and `PSLVERR`. Transfers outside the decoded window, and (optionally) transfers the target never finishes, are completed with an error response.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: start of decoded window; must be aligned to `WINDOW_BYTES`.
- `WINDOW_BYTES`, 32'h0001_0000: window size in bytes; power of two.
- `TIMEOUT_CYCLES`, 64: downstream busy limit, range 2..255. Used only with `APB_COMPLETER_TIMEOUT_EN`.

Ports:
- `CLK` in 1: clock; all state changes on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PADDR` in 32: APB address.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PWDATA` in 32: write data.
- `PSTRB` in 4: write byte strobes.
- `PPROT` in 3: accepted and ignored.
- `PRDATA` out 32: read data; valid only while `PREADY` = 1.
- `PREADY` out 1: transfer completes this cycle.
- `PSLVERR` out 1: error response; valid only while `PREADY` = 1.
- `addr` out 32: downstream address, equal to latched `PADDR`.
- `wdata` out 32: downstream write data.
- `ren` out 1: downstream read request.
- `wen` out 1: downstream write request.
- `byte_en` out 4: latched `PSTRB` on writes; 4'hF on reads.
- `rdata` in 32: downstream read data; sampled in the cycle `busy` = 0.
- `busy` in 1: downstream busy; 0 while `ren` or `wen` is asserted means the transfer is done.

## Operation
- States: IDLE, REQ, RESP, ERR.
- IDLE:
  - On `PSEL` = 1, latch `PADDR`, `PWDATA`, `PWRITE` and `PSTRB` into a request register. `PENABLE` is ignored here, so a setup phase that was skipped is still accepted.
  - If the address is inside [`BASE_ADDR`, `BASE_ADDR + WINDOW_BYTES`) and `PADDR[1:0]` = 0, go to REQ. Otherwise go to ERR.
- REQ:
  - `ren` = !wen_latched and `wen` = wen_latched. `addr`, `wdata` and `byte_en` come from the request register only, never directly from APB.
  - When `busy` = 0: capture `rdata` into the response register (reads) or load 0 (writes), then go to RESP.
- RESP: `PREADY` = 1, `PSLVERR` = err flag, `PRDATA` = response register. Next state is IDLE unconditionally.
- ERR: `PREADY` = 1, `PSLVERR` = 1, `PRDATA` = 0. No downstream request is issued. Next state is IDLE.
- `PSEL` dropped while in REQ (requester abort): the downstream request is held until `busy` = 0, the response is discarded, and the state returns to IDLE without asserting `PREADY`.
- Back-to-back transfers: a setup phase presented in the cycle after RESP or ERR (state IDLE) is accepted normally.
- Only one transfer is outstanding at a time; there is no pipelining.

## Timing
- Reset values (asynchronous, all zero): state IDLE, `PRDATA`, `PREADY`, `PSLVERR`, `ren`, `wen`, `addr`, `wdata`, `byte_en`, and the request, response and err registers.
- Setup at cycle T0 leads to REQ at T1, where `ren`/`wen` are first visible.
- If `busy` = 0 at T1, state is RESP at T2 and `PREADY` is high for exactly one cycle. Minimum transfer is 3 cycles: setup, one wait state, completion.
- Each extra cycle of `busy` = 1 in REQ adds exactly one APB wait state.
- Out-of-window or misaligned access: ERR at T1, so the transfer completes in 2 cycles with zero wait states.
- `PREADY` and `PSLVERR` are registered outputs driven from the state; there is no combinational path from `busy` to `PREADY`.
- `ren`/`wen` deassert in the cycle after `busy` is seen low.

## Configuration
- `APB_COMPLETER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle with `busy` = 1.
  - When the counter reaches `TIMEOUT_CYCLES - 1` with `busy` still 1: drop `ren`/`wen`, set the err flag, load 0 into the response register, and go to RESP. The response is `PSLVERR` = 1, `PRDATA` = 0.
  - Completion with `busy` = 0 in the same cycle as the limit takes priority and gives a normal response.
- Not defined: the counter and err path are not compiled in. REQ waits indefinitely, and RESP always drives `PSLVERR` = 0.

## Test plan
- Read at 32'h0000_0010 with `busy` low immediately and `rdata` = 32'hDEAD_BEEF -> `ren` high for 1 cycle; `PREADY` high in the third cycle with `PRDATA` = 32'hDEAD_BEEF and `PSLVERR` = 0.
- Write of 32'h1234_5678 with `PSTRB` = 4'b0101 and `busy` high for 3 cycles -> `wen`/`byte_en` = 4'b0101 held for 4 cycles; `PREADY` high after 4 wait states; `PRDATA` = 0.
- Read at 32'h0001_0000 (out of window) -> no `ren`; `PREADY` = 1 and `PSLVERR` = 1 in cycle 2.
- With `APB_COMPLETER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, `busy` stuck high -> `ren` high for 4 cycles, then `PREADY` = 1, `PSLVERR` = 1, `PRDATA` = 0; the next transfer succeeds normally.
- `nRST` asserted while in REQ -> outputs go to 0 immediately; after release, a new read completes in 3 cycles.
- `PSEL` dropped in REQ with `busy` high for 2 more cycles -> `ren` held until `busy` falls; `PREADY` never asserted; state returns to IDLE.
